// File: rtl/soc_pwm_multi_channel.sv
// soc_pwm_multi_channel: Avalon-MM slave, NUM_CH edge-aligned PWM outputs.
// Optional period interrupt enabled by defining PWM_IRQ_EN.
module soc_pwm_multi_channel #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);
    logic               bus_wr;
    logic               en;
    logic               pol;
    logic               ie;
    logic               pf;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pc;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_CH-1:0]  chen;
    logic [CNT_W-1:0]   duty    [NUM_CH];
    logic [CNT_W-1:0]   duty_sh [NUM_CH];
    logic               tick;
    logic               wrap;

    assign bus_wr = chipselect & ~write_n;
    assign tick   = en & (pc == presc);
    assign wrap   = tick & (cnt == period_sh);

    // Bus-writable configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            en     <= 1'b0;
            pol    <= 1'b0;
            presc  <= '0;
            period <= '0;
            chen   <= '0;
            for (int i = 0; i < NUM_CH; i++)
                duty[i] <= '0;
        end else if (bus_wr) begin
            case (address)
                4'd0: begin
                    en  <= writedata[0];
                    pol <= writedata[1];
                end
                4'd1: presc  <= writedata[PRESC_W-1:0];
                4'd2: period <= writedata[CNT_W-1:0];
                4'd4: chen   <= writedata[NUM_CH-1:0];
                4'd5: chen   <= chen | writedata[NUM_CH-1:0];
                4'd6: chen   <= chen & ~writedata[NUM_CH-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++)
                if (address == 4'(8 + i))
                    duty[i] <= writedata[CNT_W-1:0];
        end
    end

`ifdef PWM_IRQ_EN
    // Sticky period flag; a wrap wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ie <= 1'b0;
            pf <= 1'b0;
        end else begin
            if (bus_wr && address == 4'd0)
                ie <= writedata[2];
            if (wrap)
                pf <= 1'b1;
            else if (bus_wr && address == 4'd3 && writedata[0])
                pf <= 1'b0;
        end
    end

    assign irq = pf & ie;
`else
    assign ie  = 1'b0;
    assign pf  = 1'b0;
    assign irq = 1'b0;
`endif

    // Prescaler and period counter, held at zero while disabled
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pc  <= '0;
            cnt <= '0;
        end else begin
            pc <= tick ? '0 : pc + 1'b1;
            if (tick)
                cnt <= (cnt == period_sh) ? '0 : cnt + 1'b1;
        end
    end

    // Shadows track live registers while disabled and reload at each wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            period_sh <= '0;
            for (int i = 0; i < NUM_CH; i++)
                duty_sh[i] <= '0;
        end else if (!en || wrap) begin
            period_sh <= period;
            for (int i = 0; i < NUM_CH; i++)
                duty_sh[i] <= duty[i];
        end
    end

    // Registered compare outputs with polarity inversion
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                pwm_out[i] <= pol ^ (en & chen[i]
                                     & (cnt < duty_sh[i]));
        end
    end

    // Zero-wait-state read mux, fields zero-extended
    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata[2:0] = {ie, pol, en};
            4'd1: readdata[PRESC_W-1:0] = presc;
            4'd2: readdata[CNT_W-1:0] = period;
            4'd3: readdata[0] = pf;
            4'd4, 4'd5, 4'd6:
                readdata[NUM_CH-1:0] = chen;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++)
            if (address == 4'(8 + i))
                readdata[CNT_W-1:0] = duty[i];
    end

endmodule
